// File: rtl/mux_pkg.sv
// Shared select encoding and input count for the 4:1 mux and its usage counters.
package mux_pkg;

  typedef enum logic [1:0] {
    SEL_A = 2'd0,
    SEL_B = 2'd1,
    SEL_C = 2'd2,
    SEL_D = 2'd3
  } sel_e;

  localparam int NUM_IN = 4;

endpackage

// File: rtl/mux_if.sv
// Bundle of data, select and observation signals between a driver and the mux.
interface mux_if #(
  parameter int W     = 1,
  parameter int CNT_W = 16
);
  import mux_pkg::*;

  logic [W-1:0]            a;
  logic [W-1:0]            b;
  logic [W-1:0]            c;
  logic [W-1:0]            d;
  logic [1:0]              sel;
  logic [W-1:0]            y;
  logic [W-1:0]            y_q;
  logic [1:0]              sel_q;
  logic                    chg;
  logic [NUM_IN*CNT_W-1:0] hist;

  modport master (
    output a, b, c, d, sel,
    input  y, y_q, sel_q, chg, hist
  );

  modport slave (
    input  a, b, c, d, sel,
    output y, y_q, sel_q, chg, hist
  );

endinterface

// File: rtl/mux_sat_cnt.sv
// One select-usage counter that counts up on inc and sticks at all-ones.
module mux_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mux.sv
// 4:1 mux with registered output/select, select-change pulse and optional
// per-select usage counters (enabled by defining MUX_STATS_EN).
module mux
  import mux_pkg::*;
#(
  parameter int W     = 1,
  parameter int CNT_W = 16
) (
  input logic   clk,
  input logic   rst_n,
  mux_if.slave  bus
);

  logic [W-1:0] y_mux;

  // An unknown select falls into default and yields zeros rather than X.
  always_comb begin
    y_mux = '0;
    case (bus.sel)
      SEL_A:   y_mux = bus.a;
      SEL_B:   y_mux = bus.b;
      SEL_C:   y_mux = bus.c;
      SEL_D:   y_mux = bus.d;
      default: y_mux = '0;
    endcase
  end

  assign bus.y = y_mux;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.y_q   <= '0;
      bus.sel_q <= '0;
      bus.chg   <= 1'b0;
    end else begin
      bus.y_q   <= y_mux;
      bus.sel_q <= bus.sel;
      bus.chg   <= (bus.sel != bus.sel_q);
    end
  end

`ifdef MUX_STATS_EN
  logic [NUM_IN-1:0] inc;

  // One-hot increment; an unknown select bumps no counter.
  always_comb begin
    inc = '0;
    case (bus.sel)
      SEL_A:   inc[0] = 1'b1;
      SEL_B:   inc[1] = 1'b1;
      SEL_C:   inc[2] = 1'b1;
      SEL_D:   inc[3] = 1'b1;
      default: inc = '0;
    endcase
  end

  for (genvar k = 0; k < NUM_IN; k++) begin : g_cnt
    mux_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc[k]),
      .cnt   (bus.hist[k*CNT_W +: CNT_W])
    );
  end
`else
  assign bus.hist = '0;
`endif

endmodule

// File: tb/tb_mux.sv
// Directed bench for mux: a W=4/CNT_W=16 instance plus a CNT_W=2 instance for saturation.
module tb_mux;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  mux_if #(.W(4), .CNT_W(16)) bus0 ();
  mux_if #(.W(1), .CNT_W(2))  bus1 ();

  mux #(.W(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  mux #(.W(1), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MUX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] s, input logic [3:0] va, input logic [3:0] vb,
                       input logic [3:0] vc, input logic [3:0] vd);
    bus0.sel = s;
    bus0.a   = va;
    bus0.b   = vb;
    bus0.c   = vc;
    bus0.d   = vd;
  endtask

  logic [63:0] hist_exp;
  logic [63:0] hist_snap;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    bus1.sel  = 2'd0;
    bus1.a    = 1'b1;
    bus1.b    = 1'b0;
    bus1.c    = 1'b0;
    bus1.d    = 1'b0;
    drive(2'd0, 4'h0, 4'h0, 4'h0, 4'h0);
    #1;
    check("rst_y_q",   64'(bus0.y_q),   64'h0);
    check("rst_sel_q", 64'(bus0.sel_q), 64'h0);
    check("rst_chg",   64'(bus0.chg),   64'h0);
    check("rst_hist",  bus0.hist,       64'h0);

    // combinational select, valid during reset
    drive(2'd0, 4'h1, 4'h0, 4'h0, 4'h0); #1 check("sel0_a",   64'(bus0.y), 64'h1);
    drive(2'd1, 4'h0, 4'h1, 4'h0, 4'h0); #1 check("sel1_b",   64'(bus0.y), 64'h1);
    drive(2'd1, 4'h0, 4'h0, 4'h0, 4'h0); #1 check("sel1_zero",64'(bus0.y), 64'h0);
    drive(2'd2, 4'h0, 4'h0, 4'h1, 4'h0); #1 check("sel2_c",   64'(bus0.y), 64'h1);
    drive(2'd2, 4'h0, 4'h0, 4'h0, 4'h0); #1 check("sel2_zero",64'(bus0.y), 64'h0);
    drive(2'd3, 4'h0, 4'h0, 4'h0, 4'h1); #1 check("sel3_d",   64'(bus0.y), 64'h1);
    drive(2'd3, 4'h0, 4'h0, 4'h0, 4'h0); #1 check("sel3_zero",64'(bus0.y), 64'h0);
    drive(2'd0, 4'h5, 4'ha, 4'h3, 4'hc); #1 check("pat_a",    64'(bus0.y), 64'h5);
    bus0.sel = 2'd1;                     #1 check("pat_b",    64'(bus0.y), 64'ha);
    bus0.sel = 2'd2;                     #1 check("pat_c",    64'(bus0.y), 64'h3);
    bus0.sel = 2'd3;                     #1 check("pat_d",    64'(bus0.y), 64'hc);
    check("rst_hold_y_q", 64'(bus0.y_q), 64'h0);

    // release reset with sel=2, c=1: first edge compares against sel_q=0
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'd2, 4'h0, 4'h0, 4'h1, 4'h0);
    @(posedge clk); #1;
    check("lat_y_q",   64'(bus0.y_q),   64'h1);
    check("lat_sel_q", 64'(bus0.sel_q), 64'h2);
    check("lat_chg1",  64'(bus0.chg),   64'h1);
    @(posedge clk); #1;
    check("lat_chg0",  64'(bus0.chg),   64'h0);
    check("lat_sel_q2",64'(bus0.sel_q), 64'h2);
    hist_exp = STATS ? (64'd2 << 32) : 64'h0;
    check("hist_c2", bus0.hist, hist_exp);

    // asynchronous reset mid-count
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid_y_q",   64'(bus0.y_q),   64'h0);
    check("mid_sel_q", 64'(bus0.sel_q), 64'h0);
    check("mid_chg",   64'(bus0.chg),   64'h0);
    check("mid_hist",  bus0.hist,       64'h0);

    // usage counts: 5 edges sel=1, then 3 edges sel=3
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'd1, 4'h0, 4'h0, 4'h0, 4'h0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus0.sel = 2'd3;
    @(posedge clk); #1;
    check("st_chg1", 64'(bus0.chg), 64'h1);
    repeat (2) @(posedge clk);
    #1;
    check("st_chg0",  64'(bus0.chg),   64'h0);
    check("st_sel_q", 64'(bus0.sel_q), 64'h3);
    hist_exp = STATS ? ((64'd3 << 48) | (64'd5 << 16)) : 64'h0;
    check("st_hist", bus0.hist, hist_exp);

    // unknown select: output forced to zero, counters untouched
    @(negedge clk);
    hist_snap = hist_exp;
    drive(2'bxx, 4'h0, 4'h0, 4'h0, 4'h0);
    #1;
    check("x_y",    64'(bus0.y), 64'h0);
    check("x_hist", bus0.hist,   hist_snap);
    #1;
    bus0.sel = 2'd3;

    // saturation on the CNT_W=2 instance: 6 edges sel=0 -> 3, then held
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("sat_rst", 64'(bus1.hist), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus1.sel = 2'd0;
    repeat (6) @(posedge clk);
    #1;
    hist_exp = STATS ? 64'd3 : 64'h0;
    check("sat_6", 64'(bus1.hist), hist_exp);
    repeat (2) @(posedge clk);
    #1;
    check("sat_hold", 64'(bus1.hist), hist_exp);
    check("sat_y_q",  64'(bus1.y_q),  64'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mux.md
MUX -- requirements
Module: mux

Interface
REQ-001 The module SHALL have parameter W, default 1, giving the data width of a, b, c, d, y and y_q.
REQ-002 The module SHALL have parameter CNT_W, default 16, giving the width of each select-usage counter.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the reset, asynchronous and active-low.
REQ-005 Ports a, b, c, d, input, W bits each, SHALL be the data inputs for select codes 0, 1, 2 and 3.
REQ-006 Port sel, input, 2 bits, SHALL be the select code.
REQ-007 Port y, output, W bits, SHALL be the combinational mux output.
REQ-008 Port y_q, output, W bits, SHALL be the registered copy of y.
REQ-009 Port sel_q, output, 2 bits, SHALL be the registered copy of sel.
REQ-010 Port chg, output, 1 bit, SHALL be a one-cycle pulse indicating that the registered select changed.
REQ-011 Port hist, output, 4*CNT_W bits, SHALL carry the usage counters: slice [k*CNT_W +: CNT_W] is the count for code k.

Function
REQ-012 y SHALL equal a, b, c or d for sel = 0, 1, 2 or 3 respectively, with no clock dependency.
REQ-013 y SHALL settle within 1 time unit of any input change.
REQ-014 y SHALL be independent of rst_n, so it is valid during reset.
REQ-015 If sel contains X or Z bits, y SHALL be all-zeros; this is the mandated default branch.
REQ-016 On each rising edge of clk, y_q SHALL load y and sel_q SHALL load sel, giving 1-cycle latency.
REQ-017 On a rising edge, chg SHALL be set to 1 when the new sel differs from the current sel_q, and to 0 otherwise.
REQ-018 On every rising edge, the counter indexed by the sampled sel SHALL increment by 1.
REQ-019 Each counter SHALL saturate at 2^CNT_W-1 and hold that value without wrapping.
REQ-020 A sel containing X or Z SHALL increment no counter.
REQ-021 The four counters SHALL be independent; exactly one at most SHALL increment per cycle.

Reset
REQ-022 While rst_n = 0, y_q, sel_q, chg and all counters SHALL be 0 immediately, without waiting for clk.
REQ-023 A reset asserted mid-count SHALL clear all counters to 0.
REQ-024 After rst_n deasserts, the first rising edge SHALL behave as a normal cycle.
REQ-025 On that first edge, chg SHALL compare sel against the reset value sel_q = 0.

Configuration
REQ-026 With macro MUX_STATS_EN defined, the counters and the hist behaviour in REQ-018 to REQ-021 SHALL be compiled in.
REQ-027 With MUX_STATS_EN undefined, hist SHALL be constant 0 and no counter flops SHALL be instantiated.
REQ-028 With MUX_STATS_EN undefined, all other behaviour SHALL be unchanged.

Structure
REQ-029 Package mux_pkg SHALL hold:
- the select typedef sel_e with values SEL_A=0, SEL_B=1, SEL_C=2, SEL_D=3;
- the constant NUM_IN = 4.
REQ-030 A sub-module mux_sat_cnt (parameter CNT_W; ports clk, rst_n, inc, cnt) SHALL implement one saturating counter.
REQ-031 mux_sat_cnt SHALL be instantiated four times under MUX_STATS_EN.

Verification
REQ-032 Select 0: sel=0, a=1, b=0, c=0, d=0 -> y=1 (equals a) 1 time unit later.
REQ-033 Selects 1, 2, 3: sel=1 with only b=1, then sel=2 with only c=1, then sel=3 with only d=1 -> y=1 each time; zeroing the selected input -> y=0.
REQ-034 Reset and latency: rst_n=0 mid-run -> y_q=0, sel_q=0, chg=0, hist=0 immediately; release rst_n, hold sel=2, c=1 -> after 1 edge y_q=1, sel_q=2, chg=1; after the next edge chg=0.
REQ-035 Stats (MUX_STATS_EN defined): 5 edges with sel=1, then 3 edges with sel=3 -> hist counts {0,5,0,3}.
REQ-036 Saturation (MUX_STATS_EN defined, CNT_W=2): 6 edges with sel=0 -> count 0 = 3, held.
REQ-037 Macro off: repeat the REQ-035 stimulus -> hist=0.
REQ-038 X on select: sel=2'bx -> y=0 and no counter changes.
